// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Optional build macro UART_ARB_TAG_EN: each grant sends a tag word (9'h100 | k) before the payload.
module uart_tx_arbiter #(
    parameter int N_REQ      = 3,
    parameter int DATA_W     = 9,
    parameter int GAP_CYCLES = 1000,
    parameter int BUSY_TMO   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data9,
    input  logic                      tx_busy,
    output logic [$clog2(N_REQ)-1:0]  active_id,
    output logic                      arb_busy,
    output logic                      err_timeout
);

    localparam int ID_W     = $clog2(N_REQ);
    localparam int CNT_MAX  = (GAP_CYCLES > BUSY_TMO) ? GAP_CYCLES : BUSY_TMO;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, GAP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [ID_W-1:0]     sel;
`ifdef UART_ARB_TAG_EN
    logic                phase_q, phase_d;
    logic [DATA_W-1:0]   pay_q, pay_d;
`endif

    // First requester found after rr_q, wrapping; the smallest offset wins.
    always_comb begin
        sel = rr_q;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[(int'(rr_q) + i) % N_REQ])
                sel = ID_W'((int'(rr_q) + i) % N_REQ);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        id_d    = id_q;
        ack_d   = '0;
        start_d = 1'b0;
        data_d  = data_q;
        err_d   = err_q;
`ifdef UART_ARB_TAG_EN
        phase_d = phase_q;
        pay_d   = pay_q;
`endif
        case (state_q)
            IDLE: begin
                if ((|req) && !tx_busy) begin
                    rr_d       = sel;
                    id_d       = sel;
                    ack_d[sel] = 1'b1;
                    start_d    = 1'b1;
                    state_d    = START;
`ifdef UART_ARB_TAG_EN
                    data_d             = '0;
                    data_d[DATA_W-1]   = 1'b1;
                    data_d[ID_W-1:0]   = sel;
                    pay_d              = req_data[sel*DATA_W +: DATA_W];
                    phase_d            = 1'b0;
`else
                    data_d = req_data[sel*DATA_W +: DATA_W];
`endif
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
                    // Tag frame done: launch the payload back to back, no gap.
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        data_d  = pay_q;
                        start_d = 1'b1;
                        state_d = START;
                    end else begin
                        cnt_d   = '0;
                        state_d = GAP;
                    end
`else
                    cnt_d   = '0;
                    state_d = GAP;
`endif
                end
            end
            GAP: begin
                if (GAP_CYCLES == 0 || cnt_q == CNT_W'(GAP_LAST))
                    state_d = IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef UART_ARB_TAG_EN
            phase_q <= 1'b0;
            pay_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef UART_ARB_TAG_EN
            phase_q <= phase_d;
            pay_q   <= pay_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign tx_start    = start_q;
    assign tx_data9    = data_q;
    assign active_id   = id_q;
    assign arb_busy    = (state_q != IDLE);
    assign err_timeout = err_q;

endmodule
